rmap_cmd_encoder: RTL

Hardware RMAP command initiator. Takes one command descriptor plus a streamed write payload and serialises a complete RMAP command packet into the SpaceWire TX FIFO as 9-bit characters. It computes the header CRC and data CRC on the fly and terminates the packet with EOP, or with EEP on abort. Compared with the fixed-format 4-byte write packet builder, it adds read/write/RMW commands, variable data length, reply-address length 0..12 bytes, and an abort path. It sits in front of the TX FIFO, alongside the RMAP target top.

---
 rtl/rmap_pkg.sv | 43 ++++
 rtl/rmap_crc8.sv | 23 ++
 rtl/rmap_cmd_encoder.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/rmap_pkg.sv
// Shared RMAP constants, the CRC-8 lookup table and the command encoder state type.
package rmap_pkg;

  localparam logic [7:0] PROTOCOL_ID = 8'h01;

  // Instruction byte bit positions; packet type occupies [7:6], reply length [1:0]
  localparam int INSTR_PKT_TYPE  = 6;
  localparam int INSTR_WRITE     = 5;
  localparam int INSTR_VERIFY    = 4;
  localparam int INSTR_REPLY     = 3;
  localparam int INSTR_INCR      = 2;
  localparam int INSTR_REPLY_LEN = 0;

  localparam logic [8:0] EOP_CHAR = 9'h100;
  localparam logic [8:0] EEP_CHAR = 9'h101;

  // Reflected CRC-8, polynomial 0x07 (0xE0 reversed); T[0x01] = 0x91
  function automatic logic [255:0][7:0] build_crc_table();
    logic [255:0][7:0] t;
    logic [7:0] c;
    for (int i = 0; i < 256; i++) begin
      c = i[7:0];
      for (int b = 0; b < 8; b++) begin
        c = c[0] ? ((c >> 1) ^ 8'hE0) : (c >> 1);
      end
      t[i] = c;
    end
    return t;
  endfunction

  localparam logic [255:0][7:0] CRC_TABLE = build_crc_table();

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_HCRC,
    ST_DATA,
    ST_DCRC,
    ST_EOP,
    ST_EEP
  } state_t;

endpackage

// File: rtl/rmap_crc8.sv
// Table-driven running RMAP CRC-8 over a byte stream; clear restarts at 0x00.
module rmap_crc8
  import rmap_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       enable,
  input  logic [7:0] data,
  output logic [7:0] crc
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      crc <= 8'h00;
    end else if (clear) begin
      crc <= 8'h00;
    end else if (enable) begin
      crc <= CRC_TABLE[crc ^ data];
    end
  end

endmodule

// File: rtl/rmap_cmd_encoder.sv
// RMAP command initiator: serialises descriptor + payload into 9-bit SpaceWire
// TX FIFO characters with header/data CRCs, terminated by EOP or EEP on abort.
module rmap_cmd_encoder
  import rmap_pkg::*;
#(
  parameter int MAX_DATA_LEN    = 1024,
  parameter int LEN_WIDTH       = 24,
  parameter int MAX_REPLY_WORDS = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [7:0]                   instruction,
  input  logic [7:0]                   key,
  input  logic [7:0]                   targLogAddr,
  input  logic [7:0]                   initLogAddr,
  input  logic [15:0]                  transID,
  input  logic [7:0]                   extAddr,
  input  logic [31:0]                  addr,
  input  logic [LEN_WIDTH-1:0]         dataLen,
  input  logic [32*MAX_REPLY_WORDS-1:0] replyAddr,
  input  logic                         dataValid,
  input  logic [7:0]                   dataIn,
  output logic                         dataReady,
  input  logic                         abort,
  output logic                         txWriteEnable,
  output logic [8:0]                   txDataIn,
  input  logic                         txFull,
  output logic                         busy,
  output logic                         done,
  output logic                         rejected
);

  state_t                        state_reg;
  logic [4:0]                    hdr_cnt_reg;
  logic [LEN_WIDTH-1:0]          data_cnt_reg;
  logic                          done_reg;
  logic                          rejected_reg;

  logic [7:0]                    instr_reg;
  logic [7:0]                    key_reg;
  logic [7:0]                    targ_reg;
  logic [7:0]                    init_reg;
  logic [15:0]                   tid_reg;
  logic [7:0]                    ext_reg;
  logic [31:0]                   addr_reg;
  logic [LEN_WIDTH-1:0]          len_reg;
  logic [32*MAX_REPLY_WORDS-1:0] reply_reg;

  logic       start_bad;
  logic       accept;
  logic       has_data;
  logic       abort_now;
  logic       emit;
  logic       tx_we;
  logic [8:0] tx_char;
  logic [7:0] hdr_byte;
  logic [7:0] hdr_crc;
  logic [7:0] data_crc;
  logic [4:0] rlen4;
  logic [4:0] last_hdr;
  logic [4:0] tail_idx;
  logic [4:0] reply_sel;
  logic [7:0] reply_bytes [16];

  assign start_bad = (instruction[INSTR_PKT_TYPE +: 2] != 2'b01)
                  || ({1'b0, instruction[INSTR_REPLY_LEN +: 2]} > 3'(MAX_REPLY_WORDS))
                  || (instruction[INSTR_WRITE] && (dataLen > LEN_WIDTH'(MAX_DATA_LEN)));
  assign accept    = (state_reg == ST_IDLE) && start && !start_bad;
  assign has_data  = instr_reg[INSTR_WRITE] || (instr_reg[5:2] == 4'b0111);
  assign abort_now = abort && (state_reg != ST_IDLE) && (state_reg != ST_EEP);
  assign rlen4     = {1'b0, instr_reg[INSTR_REPLY_LEN +: 2], 2'b00};
  assign last_hdr  = 5'd14 + rlen4;
  assign tail_idx  = hdr_cnt_reg - rlen4;
  assign reply_sel = hdr_cnt_reg - 5'd4;

  for (genvar gi = 0; gi < 16; gi++) begin : g_reply
    if (gi < 4 * MAX_REPLY_WORDS) begin : g_used
      assign reply_bytes[gi] = reply_reg[8*gi +: 8];
    end else begin : g_unused
      assign reply_bytes[gi] = 8'h00;
    end
  end

  always_comb begin
    hdr_byte = 8'h00;
    if (hdr_cnt_reg < 5'd4) begin
      case (hdr_cnt_reg[1:0])
        2'd0:    hdr_byte = targ_reg;
        2'd1:    hdr_byte = PROTOCOL_ID;
        2'd2:    hdr_byte = instr_reg;
        default: hdr_byte = key_reg;
      endcase
    end else if (hdr_cnt_reg < 5'd4 + rlen4) begin
      hdr_byte = reply_bytes[reply_sel[3:0]];
    end else begin
      case (tail_idx)
        5'd4:    hdr_byte = init_reg;
        5'd5:    hdr_byte = tid_reg[15:8];
        5'd6:    hdr_byte = tid_reg[7:0];
        5'd7:    hdr_byte = ext_reg;
        5'd8:    hdr_byte = addr_reg[31:24];
        5'd9:    hdr_byte = addr_reg[23:16];
        5'd10:   hdr_byte = addr_reg[15:8];
        5'd11:   hdr_byte = addr_reg[7:0];
        5'd12:   hdr_byte = len_reg[23:16];
        5'd13:   hdr_byte = len_reg[15:8];
        5'd14:   hdr_byte = len_reg[7:0];
        default: hdr_byte = 8'h00;
      endcase
    end
  end

  always_comb begin
    emit    = 1'b0;
    tx_char = 9'h000;
    case (state_reg)
      ST_HDR:  begin emit = 1'b1;      tx_char = {1'b0, hdr_byte}; end
      ST_HCRC: begin emit = 1'b1;      tx_char = {1'b0, hdr_crc};  end
      ST_DATA: begin emit = dataValid; tx_char = {1'b0, dataIn};   end
      ST_DCRC: begin emit = 1'b1;      tx_char = {1'b0, data_crc}; end
      ST_EOP:  begin emit = 1'b1;      tx_char = EOP_CHAR;         end
      ST_EEP:  begin emit = 1'b1;      tx_char = EEP_CHAR;         end
      default: begin emit = 1'b0;      tx_char = 9'h000;           end
    endcase
  end

  // No strobe while reset is asserted so a cut-off packet leaves nothing behind
  assign tx_we = rst && emit && !txFull && !abort_now;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg    <= ST_IDLE;
      hdr_cnt_reg  <= 5'd0;
      data_cnt_reg <= '0;
      done_reg     <= 1'b0;
      rejected_reg <= 1'b0;
    end else begin
      done_reg     <= 1'b0;
      rejected_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start && start_bad) begin
            rejected_reg <= 1'b1;
          end else if (accept) begin
            state_reg    <= ST_HDR;
            hdr_cnt_reg  <= 5'd0;
            data_cnt_reg <= dataLen;
          end
        end
        default: begin
          if (abort_now) begin
            state_reg <= ST_EEP;
          end else if (tx_we) begin
            case (state_reg)
              ST_HDR: begin
                if (hdr_cnt_reg == last_hdr) state_reg <= ST_HCRC;
                else hdr_cnt_reg <= hdr_cnt_reg + 5'd1;
              end
              ST_HCRC: begin
                if (!has_data) state_reg <= ST_EOP;
                else if (data_cnt_reg == '0) state_reg <= ST_DCRC;
                else state_reg <= ST_DATA;
              end
              ST_DATA: begin
                data_cnt_reg <= data_cnt_reg - LEN_WIDTH'(1);
                if (data_cnt_reg == LEN_WIDTH'(1)) state_reg <= ST_DCRC;
              end
              ST_DCRC: state_reg <= ST_EOP;
              ST_EOP: begin
                state_reg <= ST_IDLE;
                done_reg  <= 1'b1;
              end
              default: state_reg <= ST_IDLE;
            endcase
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      instr_reg <= instruction;
      key_reg   <= key;
      targ_reg  <= targLogAddr;
      init_reg  <= initLogAddr;
      tid_reg   <= transID;
      ext_reg   <= extAddr;
      addr_reg  <= addr;
      len_reg   <= dataLen;
      reply_reg <= replyAddr;
    end
  end

  rmap_crc8 u_hdr_crc (
    .clk    (clk),
    .rst    (rst),
    .clear  (accept),
    .enable (tx_we && (state_reg == ST_HDR)),
    .data   (hdr_byte),
    .crc    (hdr_crc)
  );

  rmap_crc8 u_data_crc (
    .clk    (clk),
    .rst    (rst),
    .clear  (accept),
    .enable (tx_we && (state_reg == ST_DATA)),
    .data   (dataIn),
    .crc    (data_crc)
  );

  assign txWriteEnable = tx_we;
  assign txDataIn      = tx_char;
  assign dataReady     = tx_we && (state_reg == ST_DATA);
  assign busy          = (state_reg != ST_IDLE);
  assign done          = done_reg;
  assign rejected      = rejected_reg;

endmodule
